alu_exec_unit: RTL and testbench

//  Handshaked, registered ALU execution unit. It is the responder side of the A/B/sel operation interface.
//  An initiator offers {a,b,sel} with in_valid; the unit returns the result with flags on a valid/ready channel.

---
 rtl/alu_exec_unit.sv | 148 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Handshaked, registered ALU with single-cycle logic/add/sub and an iterative shift-add multiply.
// Optional completed-transfer counter port op_count is enabled by defining ALU_OPCOUNT_EN.
module alu_exec_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
`ifdef ALU_OPCOUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_NOT  = 3'b110,
    OP_MUL  = 3'b111
  } op_e;

  state_e             state;
  state_e             state_nxt;
  op_e                op;
  logic               accept;
  logic               is_mul;
  logic               load_logic;
  logic               load_mul;
  logic [WIDTH:0]     sum_w;
  logic [WIDTH:0]     diff_w;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic [2*WIDTH-1:0] a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  assign op         = op_e'(sel);
  assign is_mul     = (op == OP_MUL);
  assign in_ready   = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign load_logic = accept && !is_mul;
  assign load_mul   = (state == S_DONE);
  assign sum_w      = {1'b0, a} + {1'b0, b};
  assign diff_w     = {1'b0, a} - {1'b0, b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
      S_MUL:   if (cnt == LAST) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit WIDTH of the zero-extended difference is the unsigned borrow.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    case (op)
      OP_ADD:  begin res = sum_w[WIDTH-1:0];  res_c = sum_w[WIDTH];  end
      OP_SUB:  begin res = diff_w[WIDTH-1:0]; res_c = diff_w[WIDTH]; end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_XNOR: res = ~(a ^ b);
      OP_NOT:  res = ~a;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc  <= '0;
      cnt  <= '0;
    end else if (accept && is_mul) begin
      a_sh <= {{WIDTH{1'b0}}, a};
      b_sh <= b;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == S_MUL) begin
      if (b_sh[0]) acc <= acc + a_sh;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + 1'b1;
    end
  end

  // A fresh result takes priority over draining, so accept+drain keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (load_logic) begin
        out   <= res;
        carry <= res_c;
        zero  <= (res == '0);
      end else if (load_mul) begin
        out   <= acc[WIDTH-1:0];
        carry <= |acc[2*WIDTH-1:WIDTH];
        zero  <= (acc[WIDTH-1:0] == '0);
      end
      if (load_logic || load_mul) out_valid <= 1'b1;
      else if (out_ready)         out_valid <= 1'b0;
    end
  end

`ifdef ALU_OPCOUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      op_count <= '0;
    else if (out_valid && out_ready) op_count <= op_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit (WIDTH=4): table-driven vectors checked through a result scoreboard,
// plus directed latency, backpressure, no-bubble and reset-during-multiply sequences.
module tb_alu_exec_unit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out;
  logic         carry;
  logic         zero;
`ifdef ALU_OPCOUNT_EN
  logic [15:0]  op_count;
`endif

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .zero      (zero)
`ifdef ALU_OPCOUNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   sel;
    logic [W-1:0] out;
    logic         c;
    logic         z;
  } vec_t;

  typedef struct {
    logic [W-1:0] out;
    logic         c;
    logic         z;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   xfers  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Inputs change only at posedge+1; sampling at negedge sees what the next edge will use.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      xfers++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got out=%0h expected no result", out);
      end else begin
        e = sbq.pop_front();
        check("sb_out", {28'd0, out}, {28'd0, e.out});
        check("sb_carry", {31'd0, carry}, {31'd0, e.c});
        check("sb_zero", {31'd0, zero}, {31'd0, e.z});
      end
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [2:0] ts,
                      input logic [W-1:0] eo, input logic ec, input logic ez);
    int unsigned g = 0;
    in_valid = 1'b1;
    a = ta;
    b = tb;
    sel = ts;
    @(negedge clk);
    while (!in_ready && g < 100) begin
      g++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      sbq.push_back('{out: eo, c: ec, z: ez});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned g = 0;
    while (sbq.size() != 0 && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain_pending", sbq.size(), 0);
  endtask

  vec_t tbl[16];

  initial begin
    int n;
    int g;
    tbl[0]  = '{4'b0001, 4'b1101, 3'b000, 4'b1110, 1'b0, 1'b0};
    tbl[1]  = '{4'b0001, 4'b1101, 3'b001, 4'b0100, 1'b1, 1'b0};
    tbl[2]  = '{4'b1101, 4'b0000, 3'b110, 4'b0010, 1'b0, 1'b0};
    tbl[3]  = '{4'b0011, 4'b0011, 3'b100, 4'b0000, 1'b0, 1'b1};
    tbl[4]  = '{4'b0011, 4'b0101, 3'b111, 4'b1111, 1'b0, 1'b0};
    tbl[5]  = '{4'b1001, 4'b1011, 3'b111, 4'b0011, 1'b1, 1'b0};
    tbl[6]  = '{4'b1111, 4'b0001, 3'b000, 4'b0000, 1'b1, 1'b1};
    tbl[7]  = '{4'b0101, 4'b0101, 3'b001, 4'b0000, 1'b0, 1'b1};
    tbl[8]  = '{4'b1100, 4'b1010, 3'b010, 4'b1000, 1'b0, 1'b0};
    tbl[9]  = '{4'b1100, 4'b1010, 3'b011, 4'b1110, 1'b0, 1'b0};
    tbl[10] = '{4'b1100, 4'b1010, 3'b101, 4'b1001, 1'b0, 1'b0};
    tbl[11] = '{4'b1111, 4'b1111, 3'b111, 4'b0001, 1'b1, 1'b0};
    tbl[12] = '{4'b0000, 4'b1011, 3'b111, 4'b0000, 1'b0, 1'b1};
    tbl[13] = '{4'b0000, 4'b0001, 3'b001, 4'b1111, 1'b1, 1'b0};
    tbl[14] = '{4'b1111, 4'b0110, 3'b110, 4'b0000, 1'b0, 1'b1};
    tbl[15] = '{4'b0111, 4'b0111, 3'b000, 4'b1110, 1'b0, 1'b0};

    #3;
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out", {28'd0, out}, 0);
    check("rst_carry", {31'd0, carry}, 0);
    check("rst_zero", {31'd0, zero}, 0);
`ifdef ALU_OPCOUNT_EN
    check("rst_op_count", {16'd0, op_count}, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    for (int i = 0; i < 16; i++)
      send(tbl[i].a, tbl[i].b, tbl[i].sel, tbl[i].out, tbl[i].c, tbl[i].z);
    drain();

    // Latency 1 for ADD, then 4 stalled cycles with a new op pending.
    out_ready = 1'b0;
    send(4'b0001, 4'b1101, 3'b000, 4'b1110, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 4'b0101;
    b = 4'b0011;
    sel = 3'b011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 1);
      check("bp_out", {28'd0, out}, 32'h0000000e);
      check("bp_carry", {31'd0, carry}, 0);
      check("bp_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(4'b0101, 4'b0011, 3'b011, 4'b0111, 1'b0, 1'b0);
    @(negedge clk);
    check("nobubble_valid", {31'd0, out_valid}, 1);
    check("nobubble_out", {28'd0, out}, 32'h00000007);
    drain();

    // Multiply occupancy: in_ready low for WIDTH+1 cycles.
    send(4'b0011, 4'b0101, 3'b111, 4'b1111, 1'b0, 1'b0);
    n = 0;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 20) begin
      n++;
      g++;
      @(negedge clk);
    end
    check("mul_busy_cycles", n, 5);
    check("mul_done_valid", {31'd0, out_valid}, 1);
    check("mul_done_out", {28'd0, out}, 32'h0000000f);
    drain();
`ifdef ALU_OPCOUNT_EN
    check("op_count_pre_reset", {16'd0, op_count}, xfers);
`endif

    // Reset in the second multiply cycle abandons the operation.
    send(4'b1001, 4'b1011, 3'b111, 4'b0011, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sbq.delete();
    xfers = 0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 0);
    check("midrst_out", {28'd0, out}, 0);
    check("midrst_carry", {31'd0, carry}, 0);
    check("midrst_zero", {31'd0, zero}, 0);
`ifdef ALU_OPCOUNT_EN
    check("midrst_op_count", {16'd0, op_count}, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", {31'd0, out_valid}, 0);
    end
    @(posedge clk);
    #1;
    send(4'b0110, 4'b0101, 3'b000, 4'b1011, 1'b0, 1'b0);
    drain();
`ifdef ALU_OPCOUNT_EN
    check("op_count_post_reset", {16'd0, op_count}, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
